pipe_seg_adder: RTL

- Parametrised pipelined adder: WIDTH-bit operands split into NSEG = WIDTH/SEG_W segments.
- One segment is added per pipeline stage, with the carry registered between stages.
- Input and output skew registers align operands and partial sums, so the block accepts one operation per cycle.
- Adds valid/ready flow control with global stall, plus signed-overflow reporting.
- Sits in the datapath wherever wide accumulators or offset adders must close timing at full clock rate.

---
 rtl/pipe_seg_adder_pkg.sv | 51 +++++
 rtl/pipe_seg_adder_stage.sv | 69 ++++++
 rtl/pipe_seg_adder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipe_seg_adder_pkg.sv
// ============================================================================
// Module      : pipe_seg_adder_pkg
// Description : Shared constants and helper functions for the segmented
//               pipelined adder (stage count, saturation constants).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_seg_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SEG_W = 8;

  // Widest operand the saturation helpers can describe
  localparam int SAT_MAX_W = 256;

  // Number of segments, which is also the number of pipeline stages
  function automatic int calc_nseg(input int width, input int seg_w);
    if (seg_w <= 0) begin
      return 0;
    end
    return width / seg_w;
  endfunction

  // Most positive two's-complement value of the given width: 0111..1
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int width);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width - 1) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Most negative two's-complement value of the given width: 1000..0
  function automatic logic [SAT_MAX_W-1:0] sat_min(input int width);
    logic [SAT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i == width - 1) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_seg_adder_stage.sv
// ============================================================================
// Module      : seg_add_stage
// Description : One registered SEG_W-bit segment adder with carry in/out,
//               shared enable, valid pass-through and, in the top stage,
//               signed-overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_add_stage #(
  parameter int SEG_W = 8,
  parameter bit TOP   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic             valid_o,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [SEG_W:0]   add_d;
  logic [SEG_W-1:0] sum_d;
  logic             cout_d;
  logic             cmsb_d;
  logic             ovf_d;

  logic             valid_q;
  logic [SEG_W-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Segment add is one bit wider than the segment to expose the carry
  assign add_d  = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};
  assign sum_d  = add_d[SEG_W-1:0];
  assign cout_d = add_d[SEG_W];
  // Carry into the segment MSB recovered from the MSB sum bit
  assign cmsb_d = a_i[SEG_W-1] ^ b_i[SEG_W-1] ^ sum_d[SEG_W-1];
  // Only the stage holding the word MSB reports signed overflow
  assign ovf_d  = TOP & (cmsb_d ^ cout_d);

  // Stage registers advance together under the global enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/pipe_seg_adder.sv
// ============================================================================
// Module      : pipe_seg_adder
// Description : WIDTH-bit adder pipelined as NSEG = WIDTH/SEG_W segment
//               stages with registered inter-stage carry, input/output skew
//               registers, valid/ready flow control with global stall,
//               unsigned carry-out and signed-overflow flags.
//               Optional macro PIPE_SEG_ADDER_SAT_EN saturates out_sum on
//               signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_seg_adder
  import pipe_seg_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG_W = DEFAULT_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  // Reject configurations that do not split into whole segments
  generate
    if ((SEG_W < 1) || (NSEG < 1) || ((WIDTH % SEG_W) != 0)) begin : g_bad_width
      $error("pipe_seg_adder: WIDTH must be a positive multiple of SEG_W");
    end
  endgenerate

  logic              adv;
  logic [NSEG:0]     valid_c;
  logic [NSEG:0]     carry_c;
  logic [NSEG-1:0]   ovf_c;
  logic [WIDTH-1:0]  sum_c;

  // The pipeline moves whenever the output slot is empty or being drained
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  assign valid_c[0] = in_valid;
  assign carry_c[0] = in_cin;

  generate
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
      localparam int ODEP = NSEG - 1 - k;

      logic [SEG_W-1:0] a_use;
      logic [SEG_W-1:0] b_use;
      logic [SEG_W-1:0] s_stage;

      // Input skew: segment k operands wait k cycles for their carry
      if (k == 0) begin : g_no_in_skew
        assign a_use = in_a[0 +: SEG_W];
        assign b_use = in_b[0 +: SEG_W];
      end else begin : g_in_skew
        logic [SEG_W-1:0] a_skew_q [k];
        logic [SEG_W-1:0] b_skew_q [k];

        // Operand segment delay line
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < k; j++) begin
              a_skew_q[j] <= '0;
              b_skew_q[j] <= '0;
            end
          end else if (adv) begin
            a_skew_q[0] <= in_a[k*SEG_W +: SEG_W];
            b_skew_q[0] <= in_b[k*SEG_W +: SEG_W];
            for (int j = 1; j < k; j++) begin
              a_skew_q[j] <= a_skew_q[j-1];
              b_skew_q[j] <= b_skew_q[j-1];
            end
          end
        end

        assign a_use = a_skew_q[k-1];
        assign b_use = b_skew_q[k-1];
      end

      seg_add_stage #(
        .SEG_W (SEG_W),
        .TOP   (k == NSEG - 1)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (adv),
        .valid_i (valid_c[k]),
        .a_i     (a_use),
        .b_i     (b_use),
        .cin_i   (carry_c[k]),
        .valid_o (valid_c[k+1]),
        .sum_o   (s_stage),
        .cout_o  (carry_c[k+1]),
        .ovf_o   (ovf_c[k])
      );

      // Output skew: earlier segments wait for the top segment to finish
      if (ODEP == 0) begin : g_no_out_skew
        assign sum_c[k*SEG_W +: SEG_W] = s_stage;
      end else begin : g_out_skew
        logic [SEG_W-1:0] s_skew_q [ODEP];

        // Partial sum delay line
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int j = 0; j < ODEP; j++) begin
              s_skew_q[j] <= '0;
            end
          end else if (adv) begin
            s_skew_q[0] <= s_stage;
            for (int j = 1; j < ODEP; j++) begin
              s_skew_q[j] <= s_skew_q[j-1];
            end
          end
        end

        assign sum_c[k*SEG_W +: SEG_W] = s_skew_q[ODEP-1];
      end
    end
  endgenerate

  assign out_valid = valid_c[NSEG];
  assign out_cout  = carry_c[NSEG];
  // Lower stages tie their overflow output low, so this is the top stage flag
  assign out_ovf   = |ovf_c;

`ifdef PIPE_SEG_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  logic [1:0] msb_skew_q [NSEG];

  // Operand sign bits follow the word so the clamp direction is known
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NSEG; j++) begin
        msb_skew_q[j] <= 2'b00;
      end
    end else if (adv) begin
      msb_skew_q[0] <= {in_a[WIDTH-1], in_b[WIDTH-1]};
      for (int j = 1; j < NSEG; j++) begin
        msb_skew_q[j] <= msb_skew_q[j-1];
      end
    end
  end

  // Overflow implies equal operand signs: both negative clamps low
  assign out_sum = !out_ovf ? sum_c :
                   (&msb_skew_q[NSEG-1]) ? SAT_MIN : SAT_MAX;
`else
  assign out_sum = sum_c;
`endif

endmodule

`default_nettype wire
